apple_1_pia_fifo: RTL and testbench

APPLE_1_PIA_FIFO -- requirements
Module: apple_1_pia_fifo

---
 rtl/apple_1_pia_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_apple_1_pia_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_1_pia_fifo.sv
// Apple-1 style PIA register window backed by a keyboard FIFO and a display FIFO.
// Each FIFO connects to the host through a four-phase req/ack handshake.
module apple_1_pia_fifo #(
   parameter logic [15:0] BASE_ADDR = 16'hD010,
   parameter int          KBD_DEPTH = 8,
   parameter int          DSP_DEPTH = 8,
   parameter bit          UPPERCASE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] Address_Bus,
   input  logic        WE,
   input  logic [7:0]  Data_In,
   output logic [7:0]  Data_Out,
   input  logic        kbd_rdy,
   output logic        kbd_ack,
   input  logic [6:0]  kbd_data,
   output logic        dsp_rdy,
   input  logic        dsp_ack,
   output logic [6:0]  dsp_data
);
   localparam int KAW = $clog2(KBD_DEPTH);
   localparam int DAW = $clog2(DSP_DEPTH);

   typedef enum logic {K_IDLE = 1'b0, K_ACK = 1'b1} kbd_state_t;
   typedef enum logic [1:0] {D_IDLE = 2'd0, D_SHOW = 2'd1, D_REL = 2'd2} dsp_state_t;

   function automatic logic [6:0] fold_case(input logic [6:0] c);
      logic [6:0] r;
      if (UPPERCASE && (c >= 7'h61) && (c <= 7'h7A)) r = c - 7'h20;
      else r = c;
      return r;
   endfunction

   // Counts never exceed 64, so only the value 64 needs clamping.
   function automatic logic [5:0] sat6(input logic [6:0] n);
      logic [5:0] r;
      if (n[6]) r = 6'h3F;
      else r = n[5:0];
      return r;
   endfunction

   logic [6:0]     kbd_mem_r [KBD_DEPTH];
   logic [KAW-1:0] kbd_wr_ptr_r, kbd_rd_ptr_r;
   logic [6:0]     kbd_count_r, kbd_last_r;
   logic [6:0]     dsp_mem_r [DSP_DEPTH];
   logic [DAW-1:0] dsp_wr_ptr_r, dsp_rd_ptr_r;
   logic [6:0]     dsp_count_r;
   logic           dsp_ovf_r;
   kbd_state_t     kbd_state_r, kbd_state_nxt_s;
   dsp_state_t     dsp_state_r, dsp_state_nxt_s;
   logic           kbd_ack_r, dsp_rdy_r;
   logic [6:0]     dsp_data_r;
   logic [7:0]     data_out_r;

   logic       hit_s, rd_s, wr_s;
   logic [1:0] off_s;
   logic       kbd_empty_s, kbd_full_s, dsp_empty_s, dsp_full_s;
   logic       kbd_push_s, kbd_pop_s, kbd_flush_s;
   logic       dsp_push_s, dsp_pop_s, dsp_drop_s, dsp_load_s, ovf_clr_s;
   logic [6:0] kbd_head_s, dsp_head_s;
   logic       unused_s;

   assign hit_s       = (Address_Bus[15:2] == BASE_ADDR[15:2]);
   assign off_s       = Address_Bus[1:0];
   assign rd_s        = hit_s && !WE;
   assign wr_s        = hit_s && WE;
   assign kbd_empty_s = (kbd_count_r == 7'd0);
   assign kbd_full_s  = (kbd_count_r == 7'(KBD_DEPTH));
   assign dsp_empty_s = (dsp_count_r == 7'd0);
   assign dsp_full_s  = (dsp_count_r == 7'(DSP_DEPTH));
   assign kbd_head_s  = kbd_mem_r[kbd_rd_ptr_r];
   assign dsp_head_s  = dsp_mem_r[dsp_rd_ptr_r];
   assign kbd_pop_s   = rd_s && (off_s == 2'd0) && !kbd_empty_s;
   assign kbd_flush_s = wr_s && (off_s == 2'd1) && Data_In[0];
   assign dsp_push_s  = wr_s && (off_s == 2'd2) && !dsp_full_s;
   assign dsp_drop_s  = wr_s && (off_s == 2'd2) && dsp_full_s;
   assign ovf_clr_s   = wr_s && (off_s == 2'd3) && Data_In[6];
   assign unused_s    = Data_In[7];

   // Keyboard handshake: accept only when there is room, so a full FIFO back-pressures the host.
   always_comb begin
      kbd_state_nxt_s = kbd_state_r;
      kbd_push_s      = 1'b0;
      case (kbd_state_r)
         K_IDLE: begin
            if (kbd_rdy && !kbd_full_s) begin
               kbd_state_nxt_s = K_ACK;
               kbd_push_s      = !kbd_flush_s;
            end else begin
               kbd_state_nxt_s = K_IDLE;
            end
         end
         K_ACK: begin
            if (!kbd_rdy) kbd_state_nxt_s = K_IDLE;
            else kbd_state_nxt_s = K_ACK;
         end
         default: kbd_state_nxt_s = K_IDLE;
      endcase
   end

   // Display handshake: present head, pop on host ack, wait for ack release.
   always_comb begin
      dsp_state_nxt_s = dsp_state_r;
      dsp_pop_s       = 1'b0;
      dsp_load_s      = 1'b0;
      case (dsp_state_r)
         D_IDLE: begin
            if (!dsp_empty_s) begin
               dsp_state_nxt_s = D_SHOW;
               dsp_load_s      = 1'b1;
            end else begin
               dsp_state_nxt_s = D_IDLE;
            end
         end
         D_SHOW: begin
            if (dsp_ack) begin
               dsp_state_nxt_s = D_REL;
               dsp_pop_s       = 1'b1;
            end else begin
               dsp_state_nxt_s = D_SHOW;
            end
         end
         D_REL: begin
            if (!dsp_ack) dsp_state_nxt_s = D_IDLE;
            else dsp_state_nxt_s = D_REL;
         end
         default: dsp_state_nxt_s = D_IDLE;
      endcase
   end

   // FSM state and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         kbd_state_r <= K_IDLE;
         dsp_state_r <= D_IDLE;
         kbd_ack_r   <= 1'b0;
         dsp_rdy_r   <= 1'b0;
         dsp_data_r  <= 7'h00;
      end else begin
         kbd_state_r <= kbd_state_nxt_s;
         dsp_state_r <= dsp_state_nxt_s;
         kbd_ack_r   <= (kbd_state_nxt_s == K_ACK);
         dsp_rdy_r   <= (dsp_state_nxt_s == D_SHOW);
         if (dsp_load_s) dsp_data_r <= dsp_head_s;
         else dsp_data_r <= dsp_data_r;
      end
   end

   // FIFO storage writes; no reset needed since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (kbd_push_s) kbd_mem_r[kbd_wr_ptr_r] <= fold_case(kbd_data);
      if (dsp_push_s) dsp_mem_r[dsp_wr_ptr_r] <= Data_In[6:0];
   end

   // Keyboard FIFO bookkeeping; a flush overrides any coincident push.
   always_ff @(posedge clk) begin
      if (reset || kbd_flush_s) begin
         kbd_wr_ptr_r <= '0;
         kbd_rd_ptr_r <= '0;
         kbd_count_r  <= 7'd0;
      end else begin
         if (kbd_push_s) kbd_wr_ptr_r <= kbd_wr_ptr_r + KAW'(1);
         if (kbd_pop_s) kbd_rd_ptr_r <= kbd_rd_ptr_r + KAW'(1);
         case ({kbd_push_s, kbd_pop_s})
            2'b10:   kbd_count_r <= kbd_count_r + 7'd1;
            2'b01:   kbd_count_r <= kbd_count_r - 7'd1;
            default: kbd_count_r <= kbd_count_r;
         endcase
      end
   end

   // Display FIFO bookkeeping and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         dsp_wr_ptr_r <= '0;
         dsp_rd_ptr_r <= '0;
         dsp_count_r  <= 7'd0;
         dsp_ovf_r    <= 1'b0;
      end else begin
         if (dsp_push_s) dsp_wr_ptr_r <= dsp_wr_ptr_r + DAW'(1);
         if (dsp_pop_s) dsp_rd_ptr_r <= dsp_rd_ptr_r + DAW'(1);
         case ({dsp_push_s, dsp_pop_s})
            2'b10:   dsp_count_r <= dsp_count_r + 7'd1;
            2'b01:   dsp_count_r <= dsp_count_r - 7'd1;
            default: dsp_count_r <= dsp_count_r;
         endcase
         if (dsp_drop_s) dsp_ovf_r <= 1'b1;
         else if (ovf_clr_s) dsp_ovf_r <= 1'b0;
         else dsp_ovf_r <= dsp_ovf_r;
      end
   end

   // CPU read data; empty KBD reads replay the last popped character.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_r <= 8'h00;
         kbd_last_r <= 7'h00;
      end else begin
         if (kbd_pop_s) kbd_last_r <= kbd_head_s;
         if (rd_s) begin
            case (off_s)
               2'd0:    data_out_r <= kbd_empty_s ? {1'b1, kbd_last_r} : {1'b1, kbd_head_s};
               2'd1:    data_out_r <= {!kbd_empty_s, 1'b0, sat6(kbd_count_r)};
               2'd2:    data_out_r <= {dsp_full_s, 7'h00};
               2'd3:    data_out_r <= {dsp_empty_s, dsp_ovf_r, sat6(dsp_count_r)};
               default: data_out_r <= data_out_r;
            endcase
         end
      end
   end

   assign Data_Out = data_out_r;
   assign kbd_ack  = kbd_ack_r;
   assign dsp_rdy  = dsp_rdy_r;
   assign dsp_data = dsp_data_r;
endmodule

// File: tb/tb_apple_1_pia_fifo.sv
// Self-checking bench for apple_1_pia_fifo: queue-based behavioural model compared
// every cycle, plus directed register reads with hand-computed values.
module tb_apple_1_pia_fifo;
   localparam int KD = 8;
   localparam int DD = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        kbd_rdy = 1'b0;
   logic [6:0]  kbd_data = 7'h00;
   logic        dsp_ack = 1'b0;
   logic [7:0]  Data_Out;
   logic        kbd_ack, dsp_rdy;
   logic [6:0]  dsp_data;

   int n_pass = 0;
   int n_checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   apple_1_pia_fifo #(.BASE_ADDR(16'hD010), .KBD_DEPTH(KD), .DSP_DEPTH(DD), .UPPERCASE(1'b1)) dut (
      .clk(clk), .reset(reset), .Address_Bus(addr), .WE(we), .Data_In(din), .Data_Out(Data_Out),
      .kbd_rdy(kbd_rdy), .kbd_ack(kbd_ack), .kbd_data(kbd_data),
      .dsp_rdy(dsp_rdy), .dsp_ack(dsp_ack), .dsp_data(dsp_data)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: queues for the two FIFOs and flags for the handshake phases.
   logic [6:0] kq[$];
   logic [6:0] dq[$];
   logic [7:0] m_dout = 8'h00;
   logic [6:0] m_last = 7'h00;
   logic [6:0] m_ddata = 7'h00;
   bit m_kack = 1'b0, m_drdy = 1'b0, m_drel = 1'b0, m_ovf = 1'b0;

   function automatic logic [6:0] upcase(input logic [6:0] c);
      if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
      return c;
   endfunction

   always @(posedge clk) begin : model
      int k_n, d_n;
      bit rd, wr, flush, kpop, kpush, dpop;
      logic [1:0] off;
      if (reset) begin
         kq.delete(); dq.delete();
         m_dout = 8'h00; m_last = 7'h00; m_ddata = 7'h00;
         m_kack = 1'b0; m_drdy = 1'b0; m_drel = 1'b0; m_ovf = 1'b0;
      end else begin
         k_n = kq.size();
         d_n = dq.size();
         off = addr[1:0];
         rd  = (addr >= 16'hD010) && (addr <= 16'hD013) && !we;
         wr  = (addr >= 16'hD010) && (addr <= 16'hD013) && we;
         if (rd) begin
            case (off)
               2'd0: m_dout = (k_n > 0) ? {1'b1, kq[0]} : {1'b1, m_last};
               2'd1: m_dout = {(k_n > 0), 1'b0, 6'((k_n > 63) ? 63 : k_n)};
               2'd2: m_dout = {(d_n == DD), 7'd0};
               default: m_dout = {(d_n == 0), m_ovf, 6'((d_n > 63) ? 63 : d_n)};
            endcase
         end
         kpop  = rd && (off == 2'd0) && (k_n > 0);
         flush = wr && (off == 2'd1) && din[0];
         kpush = 1'b0;
         if (!m_kack) begin
            if (kbd_rdy && k_n < KD) begin m_kack = 1'b1; kpush = !flush; end
         end else if (!kbd_rdy) m_kack = 1'b0;
         dpop = 1'b0;
         if (m_drdy) begin
            if (dsp_ack) begin dpop = 1'b1; m_drdy = 1'b0; m_drel = 1'b1; end
         end else if (m_drel) begin
            if (!dsp_ack) m_drel = 1'b0;
         end else if (d_n > 0) begin
            m_drdy = 1'b1; m_ddata = dq[0];
         end
         if (kpop) begin m_last = kq[0]; void'(kq.pop_front()); end
         if (flush) kq.delete();
         else if (kpush) kq.push_back(upcase(kbd_data));
         if (dpop) void'(dq.pop_front());
         if (wr && off == 2'd2) begin
            if (d_n == DD) m_ovf = 1'b1;
            else dq.push_back(din[6:0]);
         end
         if (wr && off == 2'd3 && din[6]) m_ovf = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_data_out", Data_Out, m_dout);
         check("model_kbd_ack", {7'd0, kbd_ack}, {7'd0, m_kack});
         check("model_dsp_rdy", {7'd0, dsp_rdy}, {7'd0, m_drdy});
         check("model_dsp_data", {1'b0, dsp_data}, {1'b0, m_ddata});
      end
   end

   task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
      @(negedge clk); addr = a; we = 1'b0;
      @(negedge clk); addr = 16'h0000;
      check(name, Data_Out, exp);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk); addr = a; we = 1'b1; din = d;
      @(negedge clk); addr = 16'h0000; we = 1'b0; din = 8'h00;
   endtask

   task automatic wait_sig(input bit sel_dsp, input logic val, input string name);
      logic cur;
      cur = sel_dsp ? dsp_rdy : kbd_ack;
      for (int i = 0; i < 40 && cur !== val; i++) begin
         @(negedge clk);
         cur = sel_dsp ? dsp_rdy : kbd_ack;
      end
      check(name, {7'd0, cur}, {7'd0, val});
   endtask

   task automatic key_press(input logic [6:0] k);
      @(negedge clk); kbd_data = k; kbd_rdy = 1'b1;
      wait_sig(1'b0, 1'b1, "kbd_ack_rise");
      kbd_rdy = 1'b0;
      wait_sig(1'b0, 1'b0, "kbd_ack_fall");
   endtask

   task automatic host_take(input logic [6:0] exp);
      wait_sig(1'b1, 1'b1, "dsp_rdy_rise");
      check("dsp_data_shown", {1'b0, dsp_data}, {1'b0, exp});
      dsp_ack = 1'b1;
      wait_sig(1'b1, 1'b0, "dsp_rdy_fall");
      check("dsp_data_hold", {1'b0, dsp_data}, {1'b0, exp});
      dsp_ack = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("rst_data_out", Data_Out, 8'h00);
      check("rst_kbd_ack", {7'd0, kbd_ack}, 8'h00);
      check("rst_dsp_rdy", {7'd0, dsp_rdy}, 8'h00);
      check("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
      cpu_read(16'hD010, 8'h80, "kbd_empty_rst");
      cpu_read(16'hD013, 8'h80, "dspcr_rst");

      // key 'a': push then KBDCR visible two edges after strobe
      @(negedge clk); kbd_data = 7'h61; kbd_rdy = 1'b1;
      @(negedge clk); addr = 16'hD011;
      @(negedge clk); addr = 16'h0000;
      check("kbdcr_latency", Data_Out, 8'h81);
      check("kbd_ack_a", {7'd0, kbd_ack}, 8'h01);
      kbd_rdy = 1'b0;
      wait_sig(1'b0, 1'b0, "kbd_ack_fall_a");
      cpu_read(16'hD010, 8'hC1, "kbd_read_a");
      cpu_read(16'hD011, 8'h00, "kbdcr_empty");
      cpu_read(16'hD010, 8'hC1, "kbd_empty_last");

      // nine keys, depth eight: ninth waits for a CPU pop
      for (int i = 1; i <= 8; i++) key_press(7'h30 + 7'(i));
      @(negedge clk); kbd_data = 7'h7A; kbd_rdy = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("kbd_ack_full", {7'd0, kbd_ack}, 8'h00);
      end
      cpu_read(16'hD011, 8'h88, "kbdcr_full");
      cpu_read(16'hD010, 8'hB1, "kbd_first");
      wait_sig(1'b0, 1'b1, "kbd_ack_after_pop");
      kbd_rdy = 1'b0;
      wait_sig(1'b0, 1'b0, "kbd_ack_fall_z");
      for (int i = 2; i <= 8; i++) cpu_read(16'hD010, 8'hB0 + 8'(i), "kbd_drain");
      cpu_read(16'hD010, 8'hDA, "kbd_fold_z");
      cpu_read(16'hD011, 8'h00, "kbdcr_drained");

      // flush coincident with a push, three queued
      key_press(7'h41); key_press(7'h42); key_press(7'h43);
      @(negedge clk); kbd_data = 7'h44; kbd_rdy = 1'b1; addr = 16'hD011; we = 1'b1; din = 8'h01;
      @(negedge clk); addr = 16'h0000; we = 1'b0; din = 8'h00;
      check("kbd_ack_flush", {7'd0, kbd_ack}, 8'h01);
      kbd_rdy = 1'b0;
      wait_sig(1'b0, 1'b0, "kbd_ack_fall_flush");
      cpu_read(16'hD011, 8'h00, "kbdcr_flushed");
      cpu_read(16'hD010, 8'hDA, "kbd_flush_last");

      // CPU pop coincident with push on empty FIFO
      @(negedge clk); kbd_data = 7'h65; kbd_rdy = 1'b1; addr = 16'hD010;
      @(negedge clk); addr = 16'h0000;
      check("kbd_pop_push_empty", Data_Out, 8'hDA);
      check("kbd_ack_e", {7'd0, kbd_ack}, 8'h01);
      kbd_rdy = 1'b0;
      wait_sig(1'b0, 1'b0, "kbd_ack_fall_e");
      cpu_read(16'hD011, 8'h81, "kbdcr_one");
      cpu_read(16'hD010, 8'hC5, "kbd_fold_e");

      // display path: latency and two handshakes
      cpu_write(16'hD012, 8'h48);
      check("dsp_lat_1", {7'd0, dsp_rdy}, 8'h00);
      @(negedge clk);
      check("dsp_lat_2", {7'd0, dsp_rdy}, 8'h01);
      check("dsp_data_lat", {1'b0, dsp_data}, 8'h48);
      cpu_write(16'hD012, 8'h49);
      host_take(7'h48);
      host_take(7'h49);
      cpu_read(16'hD013, 8'h80, "dspcr_empty");

      // overflow with host idle
      for (int i = 0; i < 9; i++) cpu_write(16'hD012, 8'h50 + 8'(i));
      cpu_read(16'hD012, 8'h80, "dsp_busy");
      cpu_read(16'hD013, 8'h48, "dspcr_ovf");
      cpu_write(16'hD013, 8'h40);
      cpu_read(16'hD013, 8'h08, "dspcr_ovf_clr");

      // drain four, leaving four queued with one shown, then reset mid-handshake
      for (int i = 0; i < 4; i++) host_take(7'h50 + 7'(i));
      wait_sig(1'b1, 1'b1, "dsp_rdy_fifth");
      check("dsp_data_fifth", {1'b0, dsp_data}, 8'h54);
      cpu_read(16'hD013, 8'h04, "dspcr_four");
      @(negedge clk); kbd_data = 7'h31; kbd_rdy = 1'b1;
      wait_sig(1'b0, 1'b1, "kbd_ack_pre_reset");
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; kbd_rdy = 1'b0;
      check("rst2_dsp_rdy", {7'd0, dsp_rdy}, 8'h00);
      check("rst2_kbd_ack", {7'd0, kbd_ack}, 8'h00);
      check("rst2_data_out", Data_Out, 8'h00);
      check("rst2_dsp_data", {1'b0, dsp_data}, 8'h00);
      cpu_read(16'hD013, 8'h80, "dspcr_after_reset");
      cpu_read(16'hD011, 8'h00, "kbdcr_after_reset");
      cpu_read(16'hD010, 8'h80, "kbd_last_after_reset");

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
